// File: rtl/sha512_ctrl_if.sv
// sha512_ctrl_if: message-side and core-side signal bundle for sha512_ctrl.
// Latency: none, wires only.
// Backpressure: message side is valid/ready; core side is start/done.
// Message side: i_valid/o_ready handshake, i_first/i_last framing, i_mode
//   algorithm select, i_data 1024-bit block, o_hash/o_hash_valid digest, o_busy.
// Core side: o_core_start, o_core_data, o_core_vin towards sha512_core;
//   i_core_vout, i_core_done back from it.
// slave = the controller's view, master = the driver/core-model view.
interface sha512_ctrl_if;
  logic          i_valid;
  logic          o_ready;
  logic          i_first;
  logic          i_last;
  logic [1:0]    i_mode;
  logic [1023:0] i_data;
  logic [511:0]  o_hash;
  logic          o_hash_valid;
  logic          o_busy;
  logic          o_core_start;
  logic [1023:0] o_core_data;
  logic [511:0]  o_core_vin;
  logic [511:0]  i_core_vout;
  logic          i_core_done;

  modport slave (
    input  i_valid, i_first, i_last, i_mode, i_data, i_core_vout, i_core_done,
    output o_ready, o_hash, o_hash_valid, o_busy, o_core_start, o_core_data, o_core_vin
  );

  modport master (
    output i_valid, i_first, i_last, i_mode, i_data, i_core_vout, i_core_done,
    input  o_ready, o_hash, o_hash_valid, o_busy, o_core_start, o_core_data, o_core_vin
  );
endinterface

// File: rtl/sha512_ctrl.sv
// sha512_ctrl: message-level sequencer for one sha512_core; chains blocks, picks IV, emits digest.
// Latency: core start one cycle after block acceptance; digest one cycle after the last core done.
// Backpressure: o_ready is low from acceptance until the core finishes the block.
// Ports: i_clk, i_rst (synchronous, active-high), bus (sha512_ctrl_if.slave).
// Build option: define SHA512_CTRL_TRUNC_EN to enable SHA-384 / 512/256 / 512/224
//   (IV selection and digest truncation); without it every message is plain SHA-512.
module sha512_ctrl (
  input  logic         i_clk,
  input  logic         i_rst,
  sha512_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_e;

  localparam logic [511:0] IV512 = 512'h6a09e667f3bcc908_bb67ae8584caa73b_3c6ef372fe94f82b_a54ff53a5f1d36f1_510e527fade682d1_9b05688c2b3e6c1f_1f83d9abfb41bd6b_5be0cd19137e2179;

  state_e         state_q;
  logic           ready_q;
  logic           start_q;
  logic           hash_vld_q;
  logic           last_q;
  logic           open_q;
  logic           first_wait_q;
  logic [1023:0]  data_q;
  logic [511:0]   chain_q;
  logic [511:0]   hash_q;
  logic [511:0]   iv_d;
  logic [511:0]   hash_d;

`ifdef SHA512_CTRL_TRUNC_EN
  localparam logic [511:0] IV384 = 512'hcbbb9d5dc1059ed8_629a292a367cd507_9159015a3070dd17_152fecd8f70e5939_67332667ffc00b31_8eb44a8768581511_db0c2e0d64f98fa7_47b5481dbefa4fa4;
  localparam logic [511:0] IV256 = 512'h22312194fc2bf72c_9f555fa3c84c64c2_2393b86b6f53b151_963877195940eabd_96283ee2a88effe3_be5e1e2553863992_2b0199fc2c85b8aa_0eb72ddc81c52ca2;
  localparam logic [511:0] IV224 = 512'h8c3d37c819544da2_73e1996689dcd4d6_1dfab7ae32ff9c82_679dd514582f9fcf_0f6d2b697bd44da8_77e36f7304c48942_3f9d85a86a1d36c8_1112e6ad91d692a1;

  logic [1:0] mode_q;

  function automatic logic [511:0] iv_of(input logic [1:0] m);
    case (m)
      2'b01:   return IV384;
      2'b10:   return IV256;
      2'b11:   return IV224;
      default: return IV512;
    endcase
  endfunction

  // Digest is left-aligned; bits below the algorithm's output length are forced to zero.
  function automatic logic [511:0] mask_of(input logic [1:0] m);
    case (m)
      2'b01:   return {{384{1'b1}}, 128'h0};
      2'b10:   return {{256{1'b1}}, 256'h0};
      2'b11:   return {{224{1'b1}}, 288'h0};
      default: return {512{1'b1}};
    endcase
  endfunction

  // Mode comes straight from the bus: the IV is only loaded on the edge that latches it.
  assign iv_d   = iv_of(bus.i_mode);
  assign hash_d = bus.i_core_vout & mask_of(mode_q);
`else
  assign iv_d   = IV512;
  assign hash_d = bus.i_core_vout;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      start_q      <= 1'b0;
      hash_vld_q   <= 1'b0;
      last_q       <= 1'b0;
      open_q       <= 1'b0;
      first_wait_q <= 1'b0;
      data_q       <= '0;
      chain_q      <= '0;
      hash_q       <= '0;
`ifdef SHA512_CTRL_TRUNC_EN
      mode_q       <= 2'b00;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            data_q  <= bus.i_data;
            last_q  <= bus.i_last;
            ready_q <= 1'b0;
            start_q <= 1'b1;
            state_q <= START;
            // A first block (including one that aborts an open message) or any
            // block arriving with no message open starts a fresh chain.
            if (bus.i_first || !open_q) begin
              chain_q <= iv_d;
              open_q  <= 1'b1;
`ifdef SHA512_CTRL_TRUNC_EN
              mode_q  <= bus.i_mode;
`endif
            end
          end
        end
        START: begin
          start_q      <= 1'b0;
          first_wait_q <= 1'b1;
          state_q      <= WAIT;
        end
        WAIT: begin
          // The core's done is a level that can still be high from the previous
          // block on the first WAIT cycle, so that cycle is skipped.
          if (first_wait_q) begin
            first_wait_q <= 1'b0;
          end else if (bus.i_core_done) begin
            chain_q <= bus.i_core_vout;
            if (last_q) begin
              hash_q     <= hash_d;
              hash_vld_q <= 1'b1;
              state_q    <= OUT;
            end else begin
              ready_q <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        OUT: begin
          hash_vld_q <= 1'b0;
          open_q     <= 1'b0;
          ready_q    <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_ready      = ready_q;
  assign bus.o_core_start = start_q;
  assign bus.o_core_data  = data_q;
  assign bus.o_core_vin   = chain_q;
  assign bus.o_hash       = hash_q;
  assign bus.o_hash_valid = hash_vld_q;
  assign bus.o_busy       = open_q || (state_q != IDLE);

endmodule
